// File: rtl/comparator_serial_pkg.sv
// Shared constants for comparator_serial: FSM state encoding and result-flag bit positions.
// Build option: COMPARATOR_SIGNED_CMP_EN (see comparator_serial.sv).
package comparator_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int FLAG_LT   = 0;
    localparam int FLAG_EQ   = 1;
    localparam int FLAG_GT   = 2;
    localparam int NUM_FLAGS = 3;

    function automatic logic [NUM_FLAGS-1:0] makeFlags(input logic lt, input logic eq, input logic gt);
        logic [NUM_FLAGS-1:0] v;
        v = '0;
        v[FLAG_LT] = lt;
        v[FLAG_EQ] = eq;
        v[FLAG_GT] = gt;
        return v;
    endfunction

endpackage

// File: rtl/comparator_serial_if.sv
// Operand/result handshake bundle for comparator_serial; the producer/consumer side is the master.
interface comparator_serial_if #(
    parameter int WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic             lt;
    logic             eq;
    logic             gt;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, lt, eq, gt
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, lt, eq, gt
    );

endinterface

// File: rtl/comparator_serial_chunk_cmp.sv
// Combinational magnitude comparator for one CHUNK-wide slice of the operands.
module chunk_cmp #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    output logic             o_lt,
    output logic             o_eq,
    output logic             o_gt
);

    assign o_lt = (i_a <  i_b);
    assign o_eq = (i_a == i_b);
    assign o_gt = (i_a >  i_b);

endmodule

// File: rtl/comparator_serial.sv
// Serial magnitude comparator: walks the operands CHUNK bits per cycle from the MSB end, exiting early.
// Define COMPARATOR_SIGNED_CMP_EN for two's-complement operands; unsigned otherwise.
module comparator_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    comparator_serial_if.slave   bus
);

    import comparator_pkg::*;

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
            $error("comparator_serial: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    logic [1:0]           r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [IDX_W-1:0]     r_idx;
    logic [NUM_FLAGS-1:0] r_flags;

    logic [CHUNK-1:0]     w_sel_a;
    logic [CHUNK-1:0]     w_sel_b;
    logic [CHUNK-1:0]     w_op_a;
    logic [CHUNK-1:0]     w_op_b;
    logic                 w_lt;
    logic                 w_eq;
    logic                 w_gt;
    logic                 w_done;

    assign w_sel_a = r_a[int'(r_idx) * CHUNK +: CHUNK];
    assign w_sel_b = r_b[int'(r_idx) * CHUNK +: CHUNK];

`ifdef COMPARATOR_SIGNED_CMP_EN
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [CHUNK-1:0] SIGN_MASK = CHUNK'(1) << (CHUNK - 1);
    assign w_op_a = (r_idx == IDX_LAST) ? (w_sel_a ^ SIGN_MASK) : w_sel_a;
    assign w_op_b = (r_idx == IDX_LAST) ? (w_sel_b ^ SIGN_MASK) : w_sel_b;
`else
    assign w_op_a = w_sel_a;
    assign w_op_b = w_sel_b;
`endif

    chunk_cmp #(
        .CHUNK (CHUNK)
    ) u_chunk_cmp (
        .i_a  (w_op_a),
        .i_b  (w_op_b),
        .o_lt (w_lt),
        .o_eq (w_eq),
        .o_gt (w_gt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_flags <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_idx   <= IDX_LAST;
                        r_state <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (!w_eq) begin
                        r_flags <= makeFlags(w_lt, 1'b0, w_gt);
                        r_state <= ST_DONE;
                    end else if (r_idx == '0) begin
                        r_flags <= makeFlags(1'b0, 1'b1, 1'b0);
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx - IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_flags <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from state so reset clears them without waiting for a clock.
    assign w_done        = (r_state == ST_DONE);
    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = w_done;
    assign bus.lt        = w_done & r_flags[FLAG_LT];
    assign bus.eq        = w_done & r_flags[FLAG_EQ];
    assign bus.gt        = w_done & r_flags[FLAG_GT];

endmodule

// File: doc/comparator_serial.md
COMPARATOR_SERIAL -- requirements
Module: comparator_serial

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of CHUNK.
REQ-002 Parameter CHUNK, default 4, bits compared per cycle; 1 <= CHUNK <= WIDTH.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operands a/b present.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 lt / eq / gt  output  1 each  A<B, A==B, A>B.

Function
REQ-012 FSM states: IDLE, CMP, DONE; encoding is binary from the package.
REQ-013 IDLE: in_ready=1. On in_valid, a and b SHALL be registered, chunk index SHALL load N-1 (N=WIDTH/CHUNK), and the FSM SHALL go to CMP.
REQ-014 CMP: one chunk per cycle, MSB chunk first. On the first unequal chunk, lt/gt SHALL be set from that chunk and the FSM SHALL go to DONE (early exit).
REQ-015 CMP: if chunk 0 is equal, eq SHALL be set and the FSM SHALL go to DONE; otherwise the index SHALL decrement and CMP continues.
REQ-016 Latency: acceptance at edge T0; out_valid SHALL rise at edge T0+k, where k = (N - index of first differing chunk), or k = N when equal; minimum 1, maximum N.
REQ-017 DONE: out_valid=1; lt/eq/gt SHALL be one-hot and stable until out_ready=1, then the FSM SHALL go to IDLE on that edge.
REQ-018 No accept in DONE: in_ready=0 in CMP and DONE. Back-to-back results SHALL be spaced by at least k+1 cycles.
REQ-019 lt/eq/gt SHALL be 0 whenever out_valid=0.
REQ-020 Changes on a/b after acceptance SHALL NOT affect the result.
REQ-021 CHUNK==WIDTH (N=1): every result SHALL take exactly one CMP cycle.

Reset
REQ-022 rst_n low SHALL immediately force IDLE and in_ready=1, with out_valid=lt=eq=gt=0, regardless of state.
REQ-023 Assertion of reset mid-CMP or in DONE SHALL discard the in-flight comparison with no result emitted.
REQ-024 After rst_n deasserts, the first acceptance SHALL occur no earlier than the first rising edge with rst_n high.

Configuration
REQ-025 Macro COMPARATOR_SIGNED_CMP_EN defined: operands SHALL be two's-complement, implemented by inverting bit WIDTH-1 of both operands in the MSB chunk comparison.
REQ-026 Macro COMPARATOR_SIGNED_CMP_EN undefined: operands SHALL be unsigned, with no sign logic synthesised.

Structure
REQ-027 Package comparator_pkg SHALL hold the state encoding constants (IDLE/CMP/DONE) and the result-flag index constants.
REQ-028 Sub-module chunk_cmp (combinational, CHUNK-wide, outputs lt/eq/gt) SHALL be instantiated once and muxed by the chunk index.
REQ-029 Elaboration SHALL fail if WIDTH % CHUNK != 0.

Verification (WIDTH=16, CHUNK=4)
REQ-030 a=16'h1234, b=16'h1234, out_ready=1 -> eq=1, out_valid 4 cycles after acceptance.
REQ-031 a=16'h8000, b=16'h7FFF -> unsigned: gt=1 after 1 CMP cycle; with COMPARATOR_SIGNED_CMP_EN: lt=1.
REQ-032 a=16'h12A4, b=16'h12B4 -> lt=1, out_valid 3 cycles after acceptance.
REQ-033 Hold out_ready=0 for 5 cycles in DONE, and change a/b meanwhile -> flags stable, in_ready=0; then out_ready=1 -> IDLE next edge.
REQ-034 Pulse rst_n low during CMP of a=16'h0001, b=16'h0002 -> outputs cleared at once, no out_valid; the next accepted pair compares correctly.
REQ-035 Exhaustive sweep with CHUNK=WIDTH=4, all 256 a/b pairs -> flags match a reference model, 1-cycle CMP each.
